// File: rtl/stp_pkg.sv
// rtl/stp_pkg.sv - shared holding-FSM state type and default parameters for stp_sr_flex_word
package stp_pkg;

   // Holding register occupancy: EMPTY means word_valid=0, FULL means word_valid=1
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } hold_state_e;

   localparam int   DEF_NUM_BITS   = 8;
   localparam int   DEF_SHIFT_MSB  = 1;
   localparam logic DEF_IDLE_VALUE = 1'b1;

endpackage

// File: rtl/stp_bit_counter.sv
// rtl/stp_bit_counter.sv - rollover counter with enable, synchronous clear and rollover flag
module stp_bit_counter #(
   parameter int WIDTH     = 3,
   parameter int MAX_COUNT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             rollover
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins, otherwise advance on enable and wrap after MAX_COUNT
   always_comb begin
      rollover = enable && !clear && (count_q == MAX_C);
      count_d  = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = rollover ? '0 : count_q + WIDTH'(1);
      end
   end

   // Count register with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/stp_sr_flex_word.sv
// rtl/stp_sr_flex_word.sv - serial-to-parallel word shifter with holding register; STP_PARITY_EN adds a trailing even-parity bit
module stp_sr_flex_word
   import stp_pkg::*;
#(
   parameter int   NUM_BITS   = DEF_NUM_BITS,
   parameter int   SHIFT_MSB  = DEF_SHIFT_MSB,
   parameter logic IDLE_VALUE = DEF_IDLE_VALUE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                shift_enable,
   input  logic                serial_in,
   input  logic                word_ready,
   output logic [NUM_BITS-1:0] parallel_out,
   output logic [NUM_BITS-1:0] word_data,
   output logic                word_valid,
   output logic                overrun
`ifdef STP_PARITY_EN
   ,
   output logic                parity_error
`endif
);

`ifdef STP_PARITY_EN
   localparam int FRAME_BITS = NUM_BITS + 1;
`else
   localparam int FRAME_BITS = NUM_BITS;
`endif
   localparam int CNT_W = $clog2(FRAME_BITS);

   logic [NUM_BITS-1:0] sr_q, sr_d, sr_shift;
   logic [NUM_BITS-1:0] word_data_q, word_data_d;
   hold_state_e         state_q, state_d;
   logic                overrun_q, overrun_d;
   logic [CNT_W-1:0]    bit_cnt;
   logic                complete;
   logic                data_bit;

   stp_bit_counter #(
      .WIDTH     (CNT_W),
      .MAX_COUNT (FRAME_BITS - 1)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .enable   (shift_enable),
      .count    (bit_cnt),
      .rollover (complete)
   );

`ifdef STP_PARITY_EN
   logic parity_error_q, parity_error_d;
   // The final bit of each frame is parity and never enters the data register
   assign data_bit = (bit_cnt != CNT_W'(NUM_BITS));
`else
   logic unused_bit_cnt;
   assign unused_bit_cnt = ^bit_cnt;
   assign data_bit       = 1'b1;
`endif

   // Shift register next value: clear refills with idle, shifting only on data bits
   always_comb begin
      if (SHIFT_MSB != 0) begin
         sr_shift = {sr_q[NUM_BITS-2:0], serial_in};
      end else begin
         sr_shift = {serial_in, sr_q[NUM_BITS-1:1]};
      end
      sr_d = sr_q;
      if (clear) begin
         sr_d = {NUM_BITS{IDLE_VALUE}};
      end else if (shift_enable && data_bit) begin
         sr_d = sr_shift;
      end
   end

   // Holding FSM: load on completion unless a held word is unaccepted, then flag overrun
   always_comb begin
      state_d     = state_q;
      word_data_d = word_data_q;
      overrun_d   = clear ? 1'b0 : overrun_q;
`ifdef STP_PARITY_EN
      parity_error_d = parity_error_q;
`endif
      case (state_q)
         EMPTY: begin
            if (complete) begin
               state_d     = FULL;
               word_data_d = sr_d;
`ifdef STP_PARITY_EN
               parity_error_d = (^sr_q) ^ serial_in;
`endif
            end
         end
         FULL: begin
            if (complete && word_ready) begin
               word_data_d = sr_d;
`ifdef STP_PARITY_EN
               parity_error_d = (^sr_q) ^ serial_in;
`endif
            end else if (complete) begin
               overrun_d = 1'b1;
            end else if (word_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // All word-path state registered together; reset beats every other control
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q        <= {NUM_BITS{IDLE_VALUE}};
         word_data_q <= '0;
         state_q     <= EMPTY;
         overrun_q   <= 1'b0;
`ifdef STP_PARITY_EN
         parity_error_q <= 1'b0;
`endif
      end else begin
         sr_q        <= sr_d;
         word_data_q <= word_data_d;
         state_q     <= state_d;
         overrun_q   <= overrun_d;
`ifdef STP_PARITY_EN
         parity_error_q <= parity_error_d;
`endif
      end
   end

   assign parallel_out = sr_q;
   assign word_data    = word_data_q;
   assign word_valid   = (state_q == FULL);
   assign overrun      = overrun_q;
`ifdef STP_PARITY_EN
   assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_stp_sr_flex_word.sv
// tb/tb_stp_sr_flex_word.sv - self-checking bench for stp_sr_flex_word, MSB-first and LSB-first instances against a frame-level model
module tb_stp_sr_flex_word;

   localparam int N = 8;
`ifdef STP_PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic shift_enable = 1'b0;
   logic serial_in = 1'b0;
   logic word_ready = 1'b0;

   logic [N-1:0] pout_m, word_m, pout_l, word_l;
   logic         valid_m, ovr_m, valid_l, ovr_l;
`ifdef STP_PARITY_EN
   logic         perr_m, perr_l;
`endif

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   stp_sr_flex_word #(.NUM_BITS(N), .SHIFT_MSB(1), .IDLE_VALUE(1'b1)) u_msb (
      .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
      .serial_in(serial_in), .word_ready(word_ready),
      .parallel_out(pout_m), .word_data(word_m), .word_valid(valid_m), .overrun(ovr_m)
`ifdef STP_PARITY_EN
      , .parity_error(perr_m)
`endif
   );

   stp_sr_flex_word #(.NUM_BITS(N), .SHIFT_MSB(0), .IDLE_VALUE(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
      .serial_in(serial_in), .word_ready(word_ready),
      .parallel_out(pout_l), .word_data(word_l), .word_valid(valid_l), .overrun(ovr_l)
`ifdef STP_PARITY_EN
      , .parity_error(perr_l)
`endif
   );

   // ---------------- behavioural model ----------------
   logic         hist[$];    // every data bit that entered the register since the last fill
   logic         frame_q[$]; // bits of the frame in progress, in arrival order
   logic [N-1:0] m_word[2];
   logic         m_valid, m_ovr, m_perr;

   function automatic logic [N-1:0] model_pout(input int lsb_first);
      logic [N-1:0] v;
      for (int j = 0; j < N; j++) begin
         if (lsb_first != 0) v[N-1-j] = hist[hist.size()-1-j];
         else                v[j]     = hist[hist.size()-1-j];
      end
      return v;
   endfunction

   task automatic refill();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(1'b1);
      frame_q.delete();
   endtask

   always @(posedge clk) begin
      logic         comp;
      logic [N-1:0] wm, wl;
      logic         px;
      comp = 1'b0;
      wm = '0; wl = '0; px = 1'b0;
      if (rst) begin
         refill();
         m_word[0] = '0; m_word[1] = '0;
         m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      end else begin
         if (clear) begin
            refill();
            m_ovr = 1'b0;
         end else if (shift_enable) begin
            if (frame_q.size() < N) begin
               hist.push_back(serial_in);
               if (hist.size() > N) void'(hist.pop_front());
            end
            frame_q.push_back(serial_in);
            if (frame_q.size() == FRAME) begin
               comp = 1'b1;
               for (int i = 0; i < N; i++) begin
                  wm[N-1-i] = frame_q[i];
                  wl[i]     = frame_q[i];
               end
               foreach (frame_q[i]) px ^= frame_q[i];
               frame_q.delete();
            end
         end
         if (comp && (!m_valid || word_ready)) begin
            m_word[0] = wm; m_word[1] = wl; m_perr = px; m_valid = 1'b1;
         end else if (comp) begin
            m_ovr = 1'b1;
         end else if (m_valid && word_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pout_msb",  pout_m,  model_pout(0));
         chk("pout_lsb",  pout_l,  model_pout(1));
         chk("word_msb",  word_m,  m_word[0]);
         chk("word_lsb",  word_l,  m_word[1]);
         chk("valid_msb", valid_m, m_valid);
         chk("valid_lsb", valid_l, m_valid);
         chk("ovr_msb",   ovr_m,   m_ovr);
         chk("ovr_lsb",   ovr_l,   m_ovr);
`ifdef STP_PARITY_EN
         chk("perr_msb",  perr_m,  m_perr);
         chk("perr_lsb",  perr_l,  m_perr);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic se, input logic sin, input logic rdy, input logic clr);
      @(negedge clk);
      rst = 1'b0; shift_enable = se; serial_in = sin; word_ready = rdy; clear = clr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rst = 1'b1; shift_enable = 1'b1; serial_in = 1'b0; word_ready = 1'b1; clear = 1'b0;
      end
   endtask

   // Sends w MSB first; in parity builds p follows as the frame's last bit. rdy_last is on the completing edge.
   task automatic send_frame(input logic [N-1:0] w, input logic p, input logic rdy_last);
      for (int i = 0; i < FRAME; i++) begin
         logic b;
         b = (i < N) ? w[N-1-i] : p;
         drive(1'b1, b, (i == FRAME-1) ? rdy_last : 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [N-1:0] exp_z;

      // Reset held two clocks with serial_in=0
      do_reset(1);
      chk_en = 1'b1;
      chk("rst_pout_during", pout_m, 8'hFF);
      chk("rst_valid_during", valid_m, 1'b0);
      do_reset(1);
      idle();
      chk("rst_pout_after", pout_m, 8'hFF);
      chk("rst_valid_after", valid_m, 1'b0);
      chk("rst_word_after", word_m, 8'h00);

      // Contiguous stream 1,0,1,1,0,0,1,0
      send_frame(8'hB2, 1'b0, 1'b0);
      idle();
      chk("stream_msb", word_m, 8'hB2);
      chk("stream_lsb", word_l, 8'h4D);
      chk("stream_valid", valid_m, 1'b1);
      chk("model_msb_b2", m_word[0], 8'hB2);
      chk("model_lsb_4d", m_word[1], 8'h4D);

      // Eight zeros with one-clock pauses
      do_reset(1);
      exp_z = 8'hFF;
      for (int k = 0; k < N; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         idle();
         exp_z = exp_z << 1;
         chk("disc_shift", pout_m, exp_z);
      end
      chk("disc_final_pout", pout_m, 8'h00);
`ifndef STP_PARITY_EN
      chk("disc_word", word_m, 8'h00);
`endif

      // Overrun, then replace on the same edge as completion with word_ready
      do_reset(1);
      send_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      idle();
      chk("ovr_word_kept", word_m, 8'hA5);
      chk("ovr_flag", ovr_m, 1'b1);
      send_frame(8'h0F, 1'b0, 1'b1);
      idle();
      chk("replace_word", word_m, 8'h0F);
      chk("replace_valid", valid_m, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      chk("clear_drops_ovr", ovr_m, 1'b0);
      chk("clear_keeps_valid", valid_m, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      chk("accept_empties", valid_m, 1'b0);

      // Clear after a partial word
      do_reset(1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      chk("clear_pout", pout_m, 8'hFF);
      send_frame(8'h81, 1'b0, 1'b0);
      idle();
      chk("clear_word", word_m, 8'h81);
      chk("clear_ovr", ovr_m, 1'b0);
      chk("clear_valid", valid_m, 1'b1);

`ifdef STP_PARITY_EN
      do_reset(1);
      send_frame(8'h81, 1'b0, 1'b0);
      idle();
      chk("par_ok_word", word_m, 8'h81);
      chk("par_ok", perr_m, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1);
      idle();
      chk("par_bad", perr_m, 1'b1);
      chk("par_bad_lsb_word", word_l, 8'h81);
`endif

      // Randomised traffic
      do_reset(1);
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst          = ($urandom_range(0, 511) == 0);
         clear        = ($urandom_range(0, 63) == 0);
         shift_enable = ($urandom_range(0, 3) != 0);
         serial_in    = $urandom_range(0, 1);
         word_ready   = ($urandom_range(0, 3) == 0);
      end
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
